phase_sequencer: RTL
====================

Name: phase_sequencer

Overview:
- Drives the one-hot instruction phase vector `phase` consumed by the instruction register, register file, ALU and memory interface.
- Steps each instruction through fetch (f), register read (r), execute (x), optional memory (m) and writeback (w).
- Arbitrates the single shared memory port between instruction fetch and data access through a req/ack handshake.
- Also provides run/halt control, a bus watchdog and a retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter `instr_cnt`.
- TMO_W, 4, width of the bus watchdog counter.
- TMO_MAX, 15, cycles without `mem_ack` before a bus error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- run  in  1  level; sequencer leaves IDLE when high
- halt_op  in  1  decoder flag: the instruction in the IR is a halt; valid in phase x
- need_mem  in  1  decoder flag: the instruction is a load/store; valid in phase x
- mem_ack  in  1  memory port completion strobe, 1 cycle
- phase  out  5  one-hot: bit0=f, bit1=r, bit2=x, bit3=m, bit4=w; all zero when not executing
- imem_req  out  1  instruction-fetch request to the shared port
- dmem_req  out  1  data-access request to the shared port
- pc_inc  out  1  1-cycle pulse to advance the PC
- busy  out  1  high in any state except IDLE and HALT
- halted  out  1  high in HALT
- bus_err  out  1  sticky watchdog error
- instr_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset is synchronous and active-high on `rst`, sampled on posedge `clk`.
- Reset values: state=IDLE, phase=0, imem_req=0, dmem_req=0, pc_inc=0, busy=0, halted=0, bus_err=0, instr_cnt=0, watchdog=0.
- Reset wins over every other input, including mid-handshake. Any outstanding request is dropped the next cycle.
- States: IDLE, F, R, X, M, W, HALT, ERR. The `phase` bit for F/R/X/M/W is asserted while in that state. Outputs are registered.
- IDLE: if run=1, go to F next cycle.
- F:
  - imem_req=1.
  - Stay in F until mem_ack=1, then go to R.
  - pc_inc pulses in the cycle after the ack; it is registered with the R entry. This latches the IR while phase[f]→phase[r].
- R: one cycle, then X.
- X: one cycle. Next-state priority:
  1. halt_op=1 → HALT (instruction does not retire, no m/w).
  2. need_mem=1 → M.
  3. Otherwise → W.
- M:
  - dmem_req=1.
  - Stay in M until mem_ack=1, then go to W.
  - imem_req and dmem_req are never high together.
- W:
  - One cycle. instr_cnt increments by 1 and wraps at 2^CNT_W-1 → 0.
  - Then F if run=1, otherwise IDLE. Dropping run therefore completes the current instruction.
- HALT: halted=1, phase=0. Stays until reset (or a step, see below).
- Watchdog:
  - Counts cycles spent in F or M without mem_ack. Clears on entry to F or M and on any ack.
  - When the count reaches TMO_MAX, go to ERR, set bus_err=1 and drop requests.
  - ERR is left only via reset.
  - An ack arriving in the same cycle the count hits TMO_MAX takes priority: no error.
- mem_ack received outside F/M is ignored.

Optional Feature:
- Macro: SINGLE_STEP_EN. When defined, adds input `step` (1 bit).
- With the macro:
  - W goes to HALT instead of F regardless of run; halted=1.
  - In HALT, a step=1 pulse proceeds to F, unless the HALT was entered through halt_op, which remains terminal.
  - An internal flag records the HALT source; it is cleared by reset.
- Without the macro:
  - No `step` port; W behaves as specified above.

Test Plan:
- Plain ALU op, mem_ack 2 cycles after imem_req, need_mem=0, run held → phase sequence 01,01,01,02,04,10,01. pc_inc high exactly 1 cycle at the R entry. instr_cnt=1 after W.
- Load op, need_mem=1, dmem ack delayed 3 cycles → phase 08 held 4 cycles with dmem_req=1, imem_req=0 throughout. Then 10.
- halt_op=1 in X → next cycle halted=1, phase=00, instr_cnt unchanged. Stays halted for 20 cycles with run=1.
- No mem_ack in F with TMO_MAX=15 → bus_err=1 and imem_req=0 after 15 cycles in F. Ack on cycle 15 → no error, proceeds to R.
- rst=1 asserted while in M with dmem_req=1 → next edge: all outputs at reset values. Restart with run=1 → F.
- instr_cnt preloaded near wrap (CNT_W=4, 15 retired) → 16th W gives instr_cnt=0. With SINGLE_STEP_EN: one step pulse → exactly one instruction retires, then halted=1.

Source files
------------

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: one-hot f/r/x/m/w phase vector, shared memory port
// arbitration, run/halt control, bus watchdog and retired-instruction counter.
// Optional macro SINGLE_STEP_EN adds the `step` input for one-instruction stepping.
module phase_sequencer #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TMO_W   = 4,
  parameter int unsigned TMO_MAX = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             halt_op,
  input  logic             need_mem,
  input  logic             mem_ack,
`ifdef SINGLE_STEP_EN
  input  logic             step,
`endif
  output logic [4:0]       phase,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             pc_inc,
  output logic             busy,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_F, S_R, S_X, S_M, S_W, S_HALT, S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [TMO_W-1:0]   r_wd;
  logic [TMO_W-1:0]   w_wd_next;
  logic [TMO_W-1:0]   w_wd_inc;
  logic [CNT_W-1:0]   r_cnt;
  logic [4:0]         r_phase;
  logic               r_imem_req;
  logic               r_dmem_req;
  logic               r_pc_inc;
  logic               r_busy;
  logic               r_halted;
  logic               r_bus_err;
  logic [4:0]         w_phase;
  logic               w_imem_req;
  logic               w_dmem_req;
  logic               w_pc_inc;
  logic               w_busy;
  logic               w_halted;
  logic               w_bus_err;
`ifdef SINGLE_STEP_EN
  logic               r_halt_src;
  logic               w_halt_src_next;
`endif

  // State, watchdog, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wd       <= '0;
      r_cnt      <= '0;
      r_phase    <= '0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_pc_inc   <= 1'b0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_bus_err  <= 1'b0;
`ifdef SINGLE_STEP_EN
      r_halt_src <= 1'b0;
`endif
    end else begin
      r_state    <= w_next;
      r_wd       <= w_wd_next;
      if (r_state == S_W) r_cnt <= r_cnt + CNT_W'(1);
      r_phase    <= w_phase;
      r_imem_req <= w_imem_req;
      r_dmem_req <= w_dmem_req;
      r_pc_inc   <= w_pc_inc;
      r_busy     <= w_busy;
      r_halted   <= w_halted;
      r_bus_err  <= w_bus_err;
`ifdef SINGLE_STEP_EN
      r_halt_src <= w_halt_src_next;
`endif
    end
  end

  // Next state; watchdog defaults to zero so any entry into F/M or any ack clears it
  always_comb begin
    w_next    = r_state;
    w_wd_next = '0;
    w_wd_inc  = r_wd + TMO_W'(1);
`ifdef SINGLE_STEP_EN
    w_halt_src_next = r_halt_src;
`endif
    case (r_state)
      S_IDLE: if (run) w_next = S_F;
      S_F, S_M: begin
        if (mem_ack)                             w_next = (r_state == S_F) ? S_R : S_W;
        else if (w_wd_inc == TMO_W'(TMO_MAX))    w_next = S_ERR;
        else                                     w_wd_next = w_wd_inc;
      end
      S_R: w_next = S_X;
      S_X: begin
        if (halt_op) begin
          w_next = S_HALT;
`ifdef SINGLE_STEP_EN
          w_halt_src_next = 1'b1;
`endif
        end else if (need_mem) begin
          w_next = S_M;
        end else begin
          w_next = S_W;
        end
      end
      S_W: begin
`ifdef SINGLE_STEP_EN
        w_next          = S_HALT;
        w_halt_src_next = 1'b0;
`else
        w_next = run ? S_F : S_IDLE;
`endif
      end
      S_HALT: begin
`ifdef SINGLE_STEP_EN
        if (step && !r_halt_src) w_next = S_F;
`endif
      end
      S_ERR: w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered alongside the state
  always_comb begin
    w_phase    = '0;
    w_imem_req = 1'b0;
    w_dmem_req = 1'b0;
    w_pc_inc   = 1'b0;
    w_halted   = 1'b0;
    w_bus_err  = 1'b0;
    case (w_next)
      S_F:    begin w_phase = 5'b00001; w_imem_req = 1'b1; end
      S_R:    begin w_phase = 5'b00010; w_pc_inc   = 1'b1; end
      S_X:    w_phase = 5'b00100;
      S_M:    begin w_phase = 5'b01000; w_dmem_req = 1'b1; end
      S_W:    w_phase = 5'b10000;
      S_HALT: w_halted  = 1'b1;
      S_ERR:  w_bus_err = 1'b1;
      default: ;
    endcase
    w_busy = (w_next != S_IDLE) && (w_next != S_HALT);
  end

  assign phase     = r_phase;
  assign imem_req  = r_imem_req;
  assign dmem_req  = r_dmem_req;
  assign pc_inc    = r_pc_inc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_cnt;

endmodule
